// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - thresholds a grayscale pixel stream into sequential 1-bit frame RAM writes, with frame clear
module frame_writer #(
   parameter int ADDR_W     = 12,
   parameter int NUM_PIXELS = 4096,
   parameter int THRESH     = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              clear,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              wr_data,
   output logic [ADDR_W-1:0] wr_address,
   output logic              wr_en,
   output logic              busy,
   output logic              frame_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CLEAR = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
   localparam logic [7:0]        THRESH_V  = 8'(THRESH);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr_cnt;
   logic              write_step;
   logic              write_bit;
   logic              addr_reload;
   logic              last_step;

   // Handshake and status decode the state register only, so they are glitch-free.
   assign in_ready  = (state == LOAD);
   assign busy      = (state != IDLE);
   assign last_step = (addr_cnt == LAST_ADDR);

   // Next state plus the write decision for this cycle; clear wins over start in IDLE.
   always_comb begin
      state_nxt   = state;
      write_step  = 1'b0;
      write_bit   = 1'b0;
      addr_reload = 1'b0;
      case (state)
         IDLE: begin
            if (clear) begin
               state_nxt   = CLEAR;
               addr_reload = 1'b1;
            end else if (start) begin
               state_nxt   = LOAD;
               addr_reload = 1'b1;
            end
         end
         LOAD: begin
            if (in_valid) begin
               write_step = 1'b1;
               write_bit  = (in_data >= THRESH_V);
               if (last_step) begin
                  state_nxt = IDLE;
               end
            end
         end
         CLEAR: begin
            write_step = 1'b1;
            if (last_step) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Raster address counter: reloaded on frame entry, holds at the last address after the final write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_cnt <= '0;
      end else if (addr_reload) begin
         addr_cnt <= '0;
      end else if (write_step && !last_step) begin
         addr_cnt <= addr_cnt + ADDR_W'(1);
      end
   end

   // Registered RAM write port; address and data hold between writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_en      <= 1'b0;
         wr_data    <= 1'b0;
         wr_address <= '0;
         frame_done <= 1'b0;
      end else begin
         wr_en      <= write_step;
         frame_done <= write_step && last_step;
         if (write_step) begin
            wr_address <= addr_cnt;
            wr_data    <= write_bit;
         end
      end
   end

endmodule
